// File: rtl/cntr_window_snapshot.sv
// Windowed event counter: extends an upstream N-bit counter with an M-bit overflow
// counter over a programmable window and hands the result off through a valid/ready snapshot.
module cntr_window_snapshot #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 12,
    parameter int unsigned W = 16
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    input  logic           en_i,
    input  logic [W-1:0]   win_len_i,
    input  logic [N-1:0]   cnt_i,
    input  logic           ovrflv_i,
    output logic           cnt_rst_o,
    output logic           snap_valid_o,
    input  logic           snap_rdy_i,
    output logic [N+M-1:0] snap_cnt_o,
    output logic           snap_sat_o,
    output logic           snap_lost_o
);

    localparam int unsigned SW = N + M;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_LATCH = 2'd3;

    logic [1:0]    state_q,      state_d;
    logic [W-1:0]  timer_q,      timer_d;
    logic [M-1:0]  ext_q,        ext_d;
    logic          sat_q,        sat_d;
    logic          cnt_rst_q,    cnt_rst_d;
    logic          snap_valid_q, snap_valid_d;
    logic [SW-1:0] snap_cnt_q,   snap_cnt_d;
    logic          snap_sat_q,   snap_sat_d;
    logic          snap_lost_q,  snap_lost_d;

    logic [W-1:0]  win_load;
    logic          ext_full;
    logic [M-1:0]  ext_sum;
    logic          sat_now;
    logic [SW-1:0] cap_val;

    // A zero-length window behaves as a one-cycle window.
    assign win_load = (win_len_i == '0) ? '0 : (win_len_i - W'(1));
    assign ext_full = &ext_q;

    // Capture value for LATCH: a wrap seen in the LATCH cycle still counts.
    always_comb begin
        ext_sum = ext_q;
        sat_now = sat_q;
        if (ovrflv_i) begin
            if (ext_full) begin
                sat_now = 1'b1;
            end else begin
                ext_sum = ext_q + M'(1);
            end
        end
        cap_val = sat_now ? '1 : {ext_sum, cnt_i};
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        ext_d        = ext_q;
        sat_d        = sat_q;
        snap_valid_d = snap_valid_q;
        snap_cnt_d   = snap_cnt_q;
        snap_sat_d   = snap_sat_q;
        snap_lost_d  = snap_lost_q;

        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                ext_d   = '0;
                sat_d   = 1'b0;
                timer_d = win_load;
                state_d = en_i ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (ovrflv_i) begin
                        if (ext_full) begin
                            sat_d = 1'b1;
                        end else begin
                            ext_d = ext_q + M'(1);
                        end
                    end
                    if (timer_q == '0) begin
                        state_d = ST_LATCH;
                    end else begin
                        timer_d = timer_q - W'(1);
                    end
                end
            end
            ST_LATCH: begin
                timer_d = win_load;
                ext_d   = '0;
                sat_d   = 1'b0;
                state_d = en_i ? ST_RUN : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Snapshot register: a LATCH always wins over a same-cycle handshake.
        if (state_q == ST_LATCH) begin
            snap_valid_d = 1'b1;
            snap_cnt_d   = cap_val;
            snap_sat_d   = sat_now;
            snap_lost_d  = snap_valid_q && !snap_rdy_i;
        end else if (snap_valid_q && snap_rdy_i) begin
            snap_valid_d = 1'b0;
            snap_lost_d  = 1'b0;
        end
    end

    assign cnt_rst_d = (state_d != ST_RUN);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            ext_q        <= '0;
            sat_q        <= 1'b0;
            cnt_rst_q    <= 1'b1;
            snap_valid_q <= 1'b0;
            snap_cnt_q   <= '0;
            snap_sat_q   <= 1'b0;
            snap_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ext_q        <= ext_d;
            sat_q        <= sat_d;
            cnt_rst_q    <= cnt_rst_d;
            snap_valid_q <= snap_valid_d;
            snap_cnt_q   <= snap_cnt_d;
            snap_sat_q   <= snap_sat_d;
            snap_lost_q  <= snap_lost_d;
        end
    end

    assign cnt_rst_o    = cnt_rst_q;
    assign snap_valid_o = snap_valid_q;
    assign snap_cnt_o   = snap_cnt_q;
    assign snap_sat_o   = snap_sat_q;
    assign snap_lost_o  = snap_lost_q;

endmodule

// File: tb/tb_cntr_window_snapshot.sv
// Bench for cntr_window_snapshot: two instances (M=12 and M=2) share one modelled upstream
// counter; expected snapshots come from per-window increment counts with saturation.
module tb_cntr_window_snapshot;

    localparam int MAX_A = 65535;
    localparam int MAX_B = 63;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        en_i;
    logic [15:0] win_len_i;
    logic [3:0]  cnt_i;
    logic        ovrflv_i;
    logic        snap_rdy_i;
    logic        inc;

    logic        cnt_rst_a, valid_a, sat_a, lost_a;
    logic [15:0] cnt_a;
    logic        cnt_rst_b, valid_b, sat_b, lost_b;
    logic [5:0]  cnt_b;

    int n_cmp = 0;
    int n_bad = 0;

    bit          exp_valid, exp_lost, exp_sat_a, exp_sat_b;
    logic [15:0] exp_cnt_a;
    logic [5:0]  exp_cnt_b;
    int          win_incs;
    int          cur_len;

    cntr_window_snapshot #(.N(4), .M(12), .W(16)) u_dut_a (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .win_len_i(win_len_i),
        .cnt_i(cnt_i), .ovrflv_i(ovrflv_i), .cnt_rst_o(cnt_rst_a),
        .snap_valid_o(valid_a), .snap_rdy_i(snap_rdy_i), .snap_cnt_o(cnt_a),
        .snap_sat_o(sat_a), .snap_lost_o(lost_a)
    );

    cntr_window_snapshot #(.N(4), .M(2), .W(16)) u_dut_b (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .win_len_i(win_len_i),
        .cnt_i(cnt_i), .ovrflv_i(ovrflv_i), .cnt_rst_o(cnt_rst_b),
        .snap_valid_o(valid_b), .snap_rdy_i(snap_rdy_i), .snap_cnt_o(cnt_b),
        .snap_sat_o(sat_b), .snap_lost_o(lost_b)
    );

    always #5 clk_i = ~clk_i;

    // Upstream 4-bit counter with synchronous clear and a registered wrap pulse.
    initial begin
        cnt_i    = 4'd0;
        ovrflv_i = 1'b0;
    end
    always @(posedge clk_i) begin
        if (cnt_rst_a) begin
            cnt_i    <= 4'd0;
            ovrflv_i <= 1'b0;
        end else begin
            ovrflv_i <= inc && (cnt_i == 4'hF);
            if (inc) cnt_i <= cnt_i + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/rst_a"}, 32'(cnt_rst_a), 32'd1);
        chk({tag, "/rst_b"}, 32'(cnt_rst_b), 32'd1);
        chk({tag, "/valid_a"}, 32'(valid_a), 32'd0);
        chk({tag, "/valid_b"}, 32'(valid_b), 32'd0);
        chk({tag, "/cnt_a"}, 32'(cnt_a), 32'd0);
        chk({tag, "/cnt_b"}, 32'(cnt_b), 32'd0);
        chk({tag, "/sat_a"}, 32'(sat_a), 32'd0);
        chk({tag, "/sat_b"}, 32'(sat_b), 32'd0);
        chk({tag, "/lost_a"}, 32'(lost_a), 32'd0);
        chk({tag, "/lost_b"}, 32'(lost_b), 32'd0);
    endtask

    // One clock: update the snapshot model for the cycle just ended, then check outputs.
    task automatic step(input bit exp_rst, input bit latch_now, input string tag);
        @(posedge clk_i);
        if (latch_now) begin
            exp_lost  = exp_valid && !snap_rdy_i;
            exp_valid = 1'b1;
            exp_cnt_a = (win_incs > MAX_A) ? 16'(MAX_A) : 16'(win_incs);
            exp_sat_a = (win_incs > MAX_A);
            exp_cnt_b = (win_incs > MAX_B) ? 6'(MAX_B) : 6'(win_incs);
            exp_sat_b = (win_incs > MAX_B);
        end else if (exp_valid && snap_rdy_i) begin
            exp_valid = 1'b0;
            exp_lost  = 1'b0;
        end
        #1;
        chk({tag, "/rst_a"}, 32'(cnt_rst_a), 32'(exp_rst));
        chk({tag, "/rst_b"}, 32'(cnt_rst_b), 32'(exp_rst));
        chk({tag, "/valid_a"}, 32'(valid_a), 32'(exp_valid));
        chk({tag, "/valid_b"}, 32'(valid_b), 32'(exp_valid));
        if (exp_valid) begin
            chk({tag, "/cnt_a"}, 32'(cnt_a), 32'(exp_cnt_a));
            chk({tag, "/cnt_b"}, 32'(cnt_b), 32'(exp_cnt_b));
            chk({tag, "/sat_a"}, 32'(sat_a), 32'(exp_sat_a));
            chk({tag, "/sat_b"}, 32'(sat_b), 32'(exp_sat_b));
            chk({tag, "/lost_a"}, 32'(lost_a), 32'(exp_lost));
            chk({tag, "/lost_b"}, 32'(lost_b), 32'(exp_lost));
        end
    endtask

    function automatic logic rdy_val(input int mode, input int i);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            3:       return (i == 0);
            default: return 1'($urandom);
        endcase
    endfunction

    function automatic int eff_len(input int len);
        return (len == 0) ? 1 : len;
    endfunction

    task automatic idle(input int n, input int rdy_mode);
        for (int i = 0; i < n; i++) begin
            en_i       = 1'b0;
            inc        = 1'($urandom);
            win_len_i  = 16'($urandom);
            snap_rdy_i = rdy_val(rdy_mode, i);
            step(1'b1, 1'b0, "idle");
        end
    endtask

    // From IDLE: one IDLE cycle with en high, then CLEAR samples len.
    task automatic start(input int len);
        en_i       = 1'b1;
        inc        = 1'($urandom);
        win_len_i  = 16'($urandom);
        snap_rdy_i = 1'($urandom);
        step(1'b1, 1'b0, "to_clear");
        win_len_i  = 16'(len);
        inc        = 1'($urandom);
        snap_rdy_i = 1'($urandom);
        step(1'b0, 1'b0, "clear");
        cur_len = eff_len(len);
    endtask

    // Called on the first RUN cycle: len RUN cycles with ninc increments, then LATCH.
    task automatic run_window(input int len, input int ninc, input bit at_end,
                              input int rdy_mode, input int next_len, input bit en_after);
        bit pat[$];
        int j;
        bit t;
        for (int i = 0; i < len; i++)
            pat.push_back(at_end ? (i >= len - ninc) : (i < ninc));
        if (!at_end) begin
            for (int i = len - 1; i > 0; i--) begin
                j      = $urandom_range(i, 0);
                t      = pat[i];
                pat[i] = pat[j];
                pat[j] = t;
            end
        end
        win_incs = 0;
        for (int i = 0; i < len; i++) begin
            en_i       = 1'b1;
            inc        = pat[i];
            win_len_i  = 16'($urandom);
            snap_rdy_i = rdy_val(rdy_mode, i);
            win_incs  += int'(pat[i]);
            step(i == len - 1, 1'b0, "run");
        end
        en_i       = en_after;
        inc        = 1'($urandom);
        win_len_i  = 16'(next_len);
        snap_rdy_i = rdy_val(rdy_mode, len);
        step(!en_after, 1'b1, "latch");
        cur_len = eff_len(next_len);
    endtask

    initial begin
        int nl;
        rst_n_i    = 1'b1;
        en_i       = 1'b0;
        inc        = 1'b0;
        snap_rdy_i = 1'b0;
        win_len_i  = 16'd0;
        exp_valid  = 1'b0;
        exp_lost   = 1'b0;
        exp_sat_a  = 1'b0;
        exp_sat_b  = 1'b0;
        exp_cnt_a  = '0;
        exp_cnt_b  = '0;
        win_incs   = 0;
        cur_len    = 1;

        #2 rst_n_i = 1'b0;
        #1 chk_reset("por");
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_n_i = 1'b0;
        rst_n_i = 1'b1;
        idle(3, 2);

        // 37 increments per 64-cycle window, fully consumed
        start(64);
        run_window(cur_len, 37, 1'b0, 1, 64, 1'b1);
        run_window(cur_len, 37, 1'b0, 1, 64, 1'b1);
        // last increment wraps on the final RUN cycle
        run_window(cur_len, 16, 1'b1, 1, 200, 1'b1);

        // saturation of the narrow instance, including the 63/64 boundary
        run_window(cur_len, 100, 1'b0, 1, 200, 1'b1);
        run_window(cur_len, 63, 1'b1, 1, 200, 1'b1);
        run_window(cur_len, 64, 1'b1, 1, 20, 1'b1);
        run_window(cur_len, 3, 1'b0, 1, 20, 1'b1);

        // consumer stalled across three windows, then a single-cycle accept
        run_window(cur_len, 5, 1'b0, 0, 20, 1'b1);
        run_window(cur_len, 6, 1'b0, 0, 20, 1'b1);
        run_window(cur_len, 7, 1'b0, 0, 20, 1'b1);
        run_window(cur_len, 2, 1'b0, 3, 0, 1'b1);

        // zero-length windows
        run_window(cur_len, 1, 1'b0, 1, 0, 1'b1);
        run_window(cur_len, 0, 1'b0, 1, 0, 1'b1);
        run_window(cur_len, 1, 1'b0, 2, 0, 1'b1);
        run_window(cur_len, 1, 1'b0, 2, 17, 1'b1);

        for (int k = 0; k < 6; k++) begin
            nl = $urandom_range(40, 0);
            run_window(cur_len, $urandom_range(cur_len, 0), 1'($urandom), 2, nl, 1'b1);
        end

        // abort mid-RUN with a pending snapshot that must survive IDLE
        run_window(cur_len, $urandom_range(cur_len, 0), 1'b0, 0, 25, 1'b1);
        for (int i = 0; i < 7; i++) begin
            en_i = 1'b1; inc = 1'($urandom); snap_rdy_i = 1'b0;
            step(1'b0, 1'b0, "pre_abort");
        end
        en_i = 1'b0; inc = 1'($urandom); snap_rdy_i = 1'b0;
        step(1'b1, 1'b0, "abort");
        idle(5, 0);
        idle(2, 1);

        // enable dropped during CLEAR
        en_i = 1'b1; snap_rdy_i = 1'b1;
        step(1'b1, 1'b0, "to_clear2");
        en_i = 1'b0;
        step(1'b1, 1'b0, "clear_abort");
        idle(3, 2);

        // asynchronous reset mid-RUN with a pending snapshot
        start(12);
        run_window(cur_len, 3, 1'b0, 0, 30, 1'b1);
        for (int i = 0; i < 5; i++) begin
            en_i = 1'b1; inc = 1'b1; snap_rdy_i = 1'b0;
            step(1'b0, 1'b0, "pre_rst");
        end
        #2 rst_n_i = 1'b0;
        #1;
        exp_valid = 1'b0;
        exp_lost  = 1'b0;
        chk_reset("async_rst");
        @(posedge clk_i);
        #1 chk_reset("held_rst");
        en_i    = 1'b0;
        rst_n_i = 1'b1;
        idle(4, 2);
        start(10);
        run_window(cur_len, 4, 1'b0, 1, 10, 1'b0);
        idle(3, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
